// File: rtl/lbp_pkg.sv
// Shared types and default geometry for the LBP scan sequencer and its position tracker.
package lbp_pkg;

  localparam int DEF_IMG_W  = 128;
  localparam int DEF_IMG_H  = 128;
  localparam int DEF_ADDR_W = 14;

  typedef enum logic [2:0] {IDLE, INIT, FILL, WRITE, DONE} state_e;
  typedef enum logic [1:0] {F_RIGHT, F_LEFT, F_DOWN} fill_mode_e;

endpackage

// File: rtl/lbp_scan_pos.sv
// Center-pixel position tracker for the serpentine scan: holds x, y and direction,
// exposes the post-step position so fetch addresses can be formed on the step edge.
module lbp_scan_pos
  import lbp_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_h_i,
  input  logic              step_down_i,
  output logic [ADDR_W-1:0] x_o,
  output logic [ADDR_W-1:0] y_o,
  output logic              dir_o,
  output logic [ADDR_W-1:0] x_next_o,
  output logic [ADDR_W-1:0] y_next_o,
  output logic              row_end_o,
  output logic              last_o
);

  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] X_MAX = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] Y_MAX = ADDR_W'(IMG_H - 2);

  logic [ADDR_W-1:0] x_q, x_d, y_q, y_d;
  logic              dir_q, dir_d;

  // dir: 0 = moving right, 1 = moving left
  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    dir_d = dir_q;
    if (load_i) begin
      x_d   = ONE;
      y_d   = ONE;
      dir_d = 1'b0;
    end else if (step_down_i) begin
      y_d   = y_q + ONE;
      dir_d = ~dir_q;
    end else if (step_h_i) begin
      x_d = dir_q ? (x_q - ONE) : (x_q + ONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q   <= '0;
      y_q   <= '0;
      dir_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      dir_q <= dir_d;
    end
  end

  assign x_o       = x_q;
  assign y_o       = y_q;
  assign dir_o     = dir_q;
  assign x_next_o  = x_d;
  assign y_next_o  = y_d;
  assign row_end_o = dir_q ? (x_q == ONE) : (x_q == X_MAX);
  assign last_o    = row_end_o && (y_q == Y_MAX);

endmodule

// File: rtl/lbp_scan_ctrl.sv
// Serpentine scan sequencer: issues gray reads with window-fill commands, then a
// result write per interior pixel; raises a sticky finish at the end of the frame.
module lbp_scan_ctrl
  import lbp_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  output logic [3:0]        cycle,
  output logic              initialize,
  output logic              fill_right,
  output logic              fill_left,
  output logic              fill_down,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic              finish
);

  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
  localparam logic [3:0]        INIT_LEN = 4'd9;
  localparam logic [3:0]        FILL_LEN = 4'd3;

  state_e            state_q;
  fill_mode_e        mode_q, mode_d;
  logic [3:0]        cycle_q;
  logic              gray_req_q, init_q, fill_r_q, fill_l_q, fill_d_q;
  logic              lbp_valid_q, finish_q;
  logic [ADDR_W-1:0] gray_addr_q, lbp_addr_q;

  logic              load, step_h, step_down;
  logic [ADDR_W-1:0] x, y, x_nx, y_nx;
  logic              dir, row_end, last_px;
  logic [3:0]        idx;
  logic [ADDR_W-1:0] idx_a, fx, fy, fetch_addr, center_addr;
  logic [2:0]        fill_flags;

  assign load      = (state_q == IDLE) && gray_ready;
  assign step_h    = (state_q == WRITE) && !row_end;
  assign step_down = (state_q == WRITE) && row_end && !last_px;

  lbp_scan_pos #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_pos (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .step_h_i    (step_h),
    .step_down_i (step_down),
    .x_o         (x),
    .y_o         (y),
    .dir_o       (dir),
    .x_next_o    (x_nx),
    .y_next_o    (y_nx),
    .row_end_o   (row_end),
    .last_o      (last_px)
  );

  // Address of the fetch issued on this edge, using the post-step center and
  // the 0-based index of that fetch (equal to the current cycle count).
  always_comb begin
    idx    = ((state_q == INIT) || (state_q == FILL)) ? cycle_q : 4'd0;
    idx_a  = ADDR_W'(idx);
    mode_d = mode_q;
    if (state_q == WRITE)
      mode_d = row_end ? F_DOWN : (dir ? F_LEFT : F_RIGHT);
    fx = x_nx;
    fy = y_nx;
    if ((state_q == IDLE) || (state_q == INIT)) begin
      fx = x_nx - ONE + ADDR_W'(idx % 4'd3);
      fy = y_nx - ONE + ADDR_W'(idx / 4'd3);
    end else begin
      case (mode_d)
        F_RIGHT: begin fx = x_nx + ONE;         fy = y_nx - ONE + idx_a; end
        F_LEFT:  begin fx = x_nx - ONE;         fy = y_nx - ONE + idx_a; end
        F_DOWN:  begin fx = x_nx - ONE + idx_a; fy = y_nx + ONE;         end
        default: begin fx = x_nx;               fy = y_nx;               end
      endcase
    end
    fetch_addr  = fy * W_A + fx;
    center_addr = y * W_A + x;
    fill_flags  = {mode_d == F_RIGHT, mode_d == F_LEFT, mode_d == F_DOWN};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= F_RIGHT;
      cycle_q     <= '0;
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      init_q      <= 1'b0;
      fill_r_q    <= 1'b0;
      fill_l_q    <= 1'b0;
      fill_d_q    <= 1'b0;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      finish_q    <= 1'b0;
    end else begin
      gray_req_q  <= 1'b0;
      gray_addr_q <= '0;
      cycle_q     <= '0;
      init_q      <= 1'b0;
      {fill_r_q, fill_l_q, fill_d_q} <= 3'b000;
      lbp_valid_q <= 1'b0;
      lbp_addr_q  <= '0;
      case (state_q)
        IDLE: if (gray_ready) begin
          state_q     <= INIT;
          gray_req_q  <= 1'b1;
          gray_addr_q <= fetch_addr;
          cycle_q     <= 4'd1;
          init_q      <= 1'b1;
        end
        INIT: if (cycle_q == INIT_LEN) begin
          state_q     <= WRITE;
          lbp_valid_q <= 1'b1;
          lbp_addr_q  <= center_addr;
        end else begin
          gray_req_q  <= 1'b1;
          gray_addr_q <= fetch_addr;
          cycle_q     <= cycle_q + 4'd1;
          init_q      <= 1'b1;
        end
        FILL: if (cycle_q == FILL_LEN) begin
          state_q     <= WRITE;
          lbp_valid_q <= 1'b1;
          lbp_addr_q  <= center_addr;
        end else begin
          gray_req_q  <= 1'b1;
          gray_addr_q <= fetch_addr;
          cycle_q     <= cycle_q + 4'd1;
          {fill_r_q, fill_l_q, fill_d_q} <= fill_flags;
        end
        WRITE: if (last_px) begin
          state_q  <= DONE;
          finish_q <= 1'b1;
        end else begin
          state_q     <= FILL;
          mode_q      <= mode_d;
          gray_req_q  <= 1'b1;
          gray_addr_q <= fetch_addr;
          cycle_q     <= 4'd1;
          {fill_r_q, fill_l_q, fill_d_q} <= fill_flags;
        end
        DONE:    ;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gray_req   = gray_req_q;
  assign gray_addr  = gray_addr_q;
  assign cycle      = cycle_q;
  assign initialize = init_q;
  assign fill_right = fill_r_q;
  assign fill_left  = fill_l_q;
  assign fill_down  = fill_d_q;
  assign lbp_valid  = lbp_valid_q;
  assign lbp_addr   = lbp_addr_q;
  assign finish     = finish_q;

endmodule

// File: tb/tb_lbp_scan_ctrl.sv
// Directed vector tables for start-up and row turn, a full 128x128 frame checked
// through a window model against a random image, and a mid-FILL reset.
module tb_lbp_scan_ctrl;

  localparam int W  = 128;
  localparam int H  = 128;
  localparam int AW = 14;

  typedef struct packed {
    logic          req;
    logic [AW-1:0] addr;
    logic [3:0]    cyc;
    logic [3:0]    flags;  // {initialize, fill_right, fill_left, fill_down}
    logic          valid;
    logic [AW-1:0] laddr;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset, gray_ready;
  logic          gray_req, initialize, fill_right, fill_left, fill_down, lbp_valid, finish;
  logic [AW-1:0] gray_addr, lbp_addr;
  logic [3:0]    cycle;

  lbp_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .cycle      (cycle),
    .initialize (initialize),
    .fill_right (fill_right),
    .fill_left  (fill_left),
    .fill_down  (fill_down),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .finish     (finish)
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [7:0] img [0:W*H-1];
  int   win [9];
  vec_t start_tab [14];
  vec_t turn_tab  [8];

  function automatic vec_t mk(input logic r, input int a, input int c, input logic [3:0] f,
                              input logic v, input int la);
    vec_t t;
    t.req = r; t.addr = AW'(a); t.cyc = 4'(c); t.flags = f; t.valid = v; t.laddr = AW'(la);
    return t;
  endfunction

  function automatic vec_t sample();
    vec_t t;
    t = {gray_req, gray_addr, cycle, {initialize, fill_right, fill_left, fill_down},
         lbp_valid, lbp_addr};
    return t;
  endfunction

  task automatic check(input string name, input int idx, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, required %h", name, idx, got, exp);
    end
  endtask

  task automatic check_vec(input string name, input int idx, input vec_t exp);
    vec_t got;
    got = sample();
    check(name, idx, 64'(got), 64'(exp));
    $display("%s[%0d] req=%0b addr=%0d cycle=%0d flags=%b valid=%0b laddr=%0d",
             name, idx, got.req, got.addr, got.cyc, got.flags, got.valid, got.laddr);
  endtask

  task automatic check_zero(input string name, input int idx);
    check(name, idx, 64'({sample(), finish}), 64'd0);
  endtask

  // Wait (bounded) for the first INIT fetch cycle.
  task automatic wait_req(input string name, output bit ok);
    int n;
    n = 0;
    while (!gray_req && n < 8) begin
      @(negedge clk);
      n++;
    end
    ok = gray_req;
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: gray_req not seen within 8 cycles (got 0, required 1)", name);
    end
  endtask

  // LBP code: bit k set when the k-th neighbour (raster order, center skipped) >= center.
  function automatic logic [7:0] lbp_code(input int g[9]);
    logic [7:0] c;
    int k;
    c = '0; k = 0;
    for (int i = 0; i < 9; i++) begin
      if (i != 4) begin
        c[k] = (g[i] >= g[4]);
        k++;
      end
    end
    return c;
  endfunction

  function automatic logic [7:0] ref_code(input int cx, input int cy);
    int g[9];
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        g[r*3+c] = int'(img[(cy-1+r)*W + (cx-1+c)]);
    return lbp_code(g);
  endfunction

  task automatic model_fetch();
    int d, r;
    d = int'(img[gray_addr]);
    r = int'(cycle) - 1;
    if (initialize) begin
      for (int i = 0; i < 8; i++) win[i] = win[i+1];
      win[8] = d;
    end else if (r >= 0 && r < 3) begin
      if (fill_right) begin
        win[r*3] = win[r*3+1]; win[r*3+1] = win[r*3+2]; win[r*3+2] = d;
      end else if (fill_left) begin
        win[r*3+2] = win[r*3+1]; win[r*3+1] = win[r*3]; win[r*3] = d;
      end else if (fill_down) begin
        win[r] = win[3+r]; win[3+r] = win[6+r]; win[6+r] = d;
      end
    end
  endtask

  initial begin
    int cyc, turn_pos, n_valid, last_addr, cx, cy, nflag;
    bit ok;
    logic [7:0] got_code;

    for (int i = 0; i < W*H; i++) img[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 9; i++) win[i] = 0;
    begin
      int ia[9];
      ia = '{0, 1, 2, 128, 129, 130, 256, 257, 258};
      for (int i = 0; i < 9; i++) start_tab[i] = mk(1'b1, ia[i], i + 1, 4'b1000, 1'b0, 0);
    end
    start_tab[9]  = mk(1'b0, 0,   0, 4'b0000, 1'b1, 129);
    start_tab[10] = mk(1'b1, 3,   1, 4'b0100, 1'b0, 0);
    start_tab[11] = mk(1'b1, 131, 2, 4'b0100, 1'b0, 0);
    start_tab[12] = mk(1'b1, 259, 3, 4'b0100, 1'b0, 0);
    start_tab[13] = mk(1'b0, 0,   0, 4'b0000, 1'b1, 130);
    turn_tab[0] = mk(1'b1, 509, 1, 4'b0001, 1'b0, 0);
    turn_tab[1] = mk(1'b1, 510, 2, 4'b0001, 1'b0, 0);
    turn_tab[2] = mk(1'b1, 511, 3, 4'b0001, 1'b0, 0);
    turn_tab[3] = mk(1'b0, 0,   0, 4'b0000, 1'b1, 382);
    turn_tab[4] = mk(1'b1, 252, 1, 4'b0010, 1'b0, 0);
    turn_tab[5] = mk(1'b1, 380, 2, 4'b0010, 1'b0, 0);
    turn_tab[6] = mk(1'b1, 508, 3, 4'b0010, 1'b0, 0);
    turn_tab[7] = mk(1'b0, 0,   0, 4'b0000, 1'b1, 381);

    reset = 1'b1;
    gray_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_state", 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_zero("idle_hold", i);
    end

    gray_ready = 1'b1;
    @(negedge clk);
    wait_req("frame_start", ok);
    gray_ready = 1'b0;  // deassertion mid-scan must be ignored

    cyc = 0; turn_pos = -1; n_valid = 0; last_addr = -1;
    while (ok && !finish && cyc < 70000) begin
      if (cyc < 14) check_vec("start", cyc, start_tab[cyc]);
      if (turn_pos >= 0 && turn_pos < 8) begin
        check_vec("turn", turn_pos, turn_tab[turn_pos]);
        turn_pos++;
      end
      nflag = int'(initialize) + int'(fill_right) + int'(fill_left) + int'(fill_down);
      if (gray_req) check("fetch_flags", cyc, 64'({nflag, cycle != 4'd0}), 64'({32'd1, 1'b1}));
      else          check("idle_flags",  cyc, 64'({nflag, cycle}),         64'd0);
      if (gray_req) model_fetch();
      if (lbp_valid) begin
        n_valid++;
        last_addr = int'(lbp_addr);
        cx = int'(lbp_addr) % W;
        cy = int'(lbp_addr) / W;
        if (cx < 1 || cx > W - 2 || cy < 1 || cy > H - 2) begin
          n_cmp++; n_fail++;
          $display("FAIL lbp_center[%0d]: got addr %0d, required an interior pixel", n_valid, lbp_addr);
        end else begin
          got_code = lbp_code(win);
          check("lbp_value", n_valid, 64'(got_code), 64'(ref_code(cx, cy)));
        end
        if (lbp_addr == AW'(254) && turn_pos < 0) turn_pos = 0;
      end
      @(negedge clk);
      cyc++;
    end

    check("finish_seen",   0, 64'(finish), 64'd1);
    check("finish_cycles", 0, 64'(cyc), 64'd63510);
    check("lbp_count",     0, 64'(n_valid), 64'd15876);
    check("last_lbp_addr", 0, 64'(last_addr), 64'd16129);
    check("turn_checked",  0, 64'(turn_pos), 64'd8);
    $display("frame done: %0d writes, finish after %0d cycles", n_valid, cyc);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("done_hold", i, 64'({sample(), finish}), 64'({38'd0, 1'b1}));
    end

    // Reset in the middle of a FILL, then restart.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    gray_ready = 1'b1;
    @(negedge clk);
    wait_req("restart1", ok);
    gray_ready = 1'b0;
    begin
      int n;
      n = 0;
      while (!(fill_right && cycle == 4'd2) && n < 30) begin
        @(negedge clk);
        n++;
      end
      check("reach_fill_c2", 0, 64'({fill_right, cycle}), 64'({1'b1, 4'd2}));
    end
    reset = 1'b1;
    @(negedge clk);
    check_zero("reset_mid_fill", 0);
    reset = 1'b0;
    gray_ready = 1'b1;
    @(negedge clk);
    wait_req("restart2", ok);
    gray_ready = 1'b0;
    if (ok) begin
      for (int i = 0; i < 10; i++) begin
        check_vec("reinit", i, start_tab[i]);
        @(negedge clk);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
